// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared constants and types for the two-port SRAM arbiter.
//   BITS / ADDR_WIDTH / WORD_DEPTH : geometry of the fakeram45_256x34 macro
//   state_e                        : controller FSM states (SCRUB, RUN)
//   req_t                          : one requester command (we, addr, wdata, wmask)
//   rsp_tag_t                      : read-return tag carried beside the macro latency
package sram_arb_pkg;

  localparam int BITS       = 34;
  localparam int ADDR_WIDTH = 8;
  localparam int WORD_DEPTH = 256;

  // Port identifiers as carried in the response tag.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BITS-1:0]       wdata;
    logic [BITS-1:0]       wmask;
  } req_t;

  typedef struct packed {
    logic valid;
    logic port;
    logic is_read;
  } rsp_tag_t;

  // A tag describes a read that must produce a response.
  function automatic logic tag_is_read_for(input rsp_tag_t tag, input logic port);
    return tag.valid & tag.is_read & (tag.port == port);
  endfunction

endpackage

// File: rtl/sram_arbiter_2p_if.sv
// sram_arbiter_2p_if: one requester's valid/ready request channel plus its
// read-response channel.
//   req_valid/req_ready             : request handshake (ready driven by arbiter)
//   req_we/req_addr/req_wdata/wmask : request payload
//   rsp_valid/rsp_rdata             : one-cycle read strobe and held read data
// Modports: master = memory client, slave = arbiter.
interface sram_arbiter_2p_if #(
  parameter int BITS       = sram_arb_pkg::BITS,
  parameter int ADDR_WIDTH = sram_arb_pkg::ADDR_WIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [BITS-1:0]       req_wdata;
  logic [BITS-1:0]       req_wmask;
  logic                  rsp_valid;
  logic [BITS-1:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_arbiter_2p_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n : clock and synchronous active-low reset
//   req[1:0]   : request vector (bit 0 = port A, bit 1 = port B)
//   gnt[1:0]   : one-hot grant, combinational from req and the pointer
// The pointer names the port that wins a tie; after any grant it moves to
// the port that was not granted, and it holds when nothing is granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;  // 0: A wins a tie, 1: B wins a tie
  logic ptr_d;

  // Grant decode: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer next state: point away from whoever was just granted.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram_arbiter_2p.sv
// sram_arbiter_2p: front end for one single-port 256x34 SRAM macro with a
// 1-cycle registered read. Zero-fills the array after reset, then
// round-robins requests from ports A and B onto the macro command port and
// steers read data back to the issuing port three cycles after accept.
//   clk, rst_n           : clock, synchronous active-low reset
//   init_done            : high from the first RUN cycle until the next reset
//   a, b                 : requester channels (sram_arbiter_2p_if.slave)
//   mem_ce/mem_we        : registered macro chip/write enable
//   mem_addr/wd/w_mask   : registered macro address, write data, bit mask
//   mem_rd               : macro read data (valid the cycle after a read command)
module sram_arbiter_2p #(
  parameter int BITS       = 34,
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_DEPTH = 256,
  parameter bit SCRUB_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  sram_arbiter_2p_if.slave      a,
  sram_arbiter_2p_if.slave      b,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BITS-1:0]       mem_wd,
  output logic [BITS-1:0]       mem_w_mask,
  input  logic [BITS-1:0]       mem_rd
);

  import sram_arb_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(WORD_DEPTH - 1);
  localparam state_e                RESET_STATE = (SCRUB_EN == 1'b1) ? SCRUB : RUN;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] scrub_cnt_q;
  logic                  init_done_q;

  logic [1:0]            arb_req;
  logic [1:0]            gnt;
  req_t                  sel_req;

  logic                  mem_ce_d, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [BITS-1:0]       mem_wd_d, mem_w_mask_d;
  logic                  mem_ce_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [BITS-1:0]       mem_wd_q, mem_w_mask_q;

  // tag0 sits beside the command register, tag1 beside mem_rd.
  rsp_tag_t              tag_d, tag0_q, tag1_q;
  logic                  rsp_hit_a, rsp_hit_b;
  logic                  a_rsp_valid_q, b_rsp_valid_q;
  logic [BITS-1:0]       a_rsp_rdata_q, b_rsp_rdata_q;

  // Requests only compete once the array is initialised.
  assign arb_req = (state_q == RUN) ? {b.req_valid, a.req_valid} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arb_req),
    .gnt   (gnt)
  );

  assign a.req_ready = gnt[0];
  assign b.req_ready = gnt[1];

  // Payload of the winning port (A when nobody wins; it is then unused).
  always_comb begin
    if (gnt[1]) begin
      sel_req = '{we: b.req_we, addr: b.req_addr, wdata: b.req_wdata, wmask: b.req_wmask};
    end else begin
      sel_req = '{we: a.req_we, addr: a.req_addr, wdata: a.req_wdata, wmask: a.req_wmask};
    end
  end

  // Next macro command and its response tag; idle cycles drive all zeros.
  always_comb begin
    mem_ce_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wd_d     = '0;
    mem_w_mask_d = '0;
    tag_d        = '0;
    case (state_q)
      SCRUB: begin
        mem_ce_d     = 1'b1;
        mem_we_d     = 1'b1;
        mem_addr_d   = scrub_cnt_q;
        mem_wd_d     = '0;
        mem_w_mask_d = '1;
      end
      RUN: begin
        if (gnt != 2'b00) begin
          mem_ce_d     = 1'b1;
          mem_we_d     = sel_req.we;
          mem_addr_d   = sel_req.addr;
          mem_wd_d     = sel_req.wdata;
          mem_w_mask_d = sel_req.wmask;
          tag_d        = '{valid: 1'b1, port: gnt[1], is_read: ~sel_req.we};
        end else begin
          mem_ce_d     = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = '0;
          mem_wd_d     = '0;
          mem_w_mask_d = '0;
          tag_d        = '0;
        end
      end
      default: begin
        mem_ce_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wd_d     = '0;
        mem_w_mask_d = '0;
        tag_d        = '0;
      end
    endcase
  end

  // Controller FSM: scrub counter, init_done and the macro command register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RESET_STATE;
      scrub_cnt_q  <= '0;
      init_done_q  <= 1'b0;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
      mem_w_mask_q <= '0;
    end else begin
      mem_ce_q     <= mem_ce_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
      mem_w_mask_q <= mem_w_mask_d;
      case (state_q)
        SCRUB: begin
          scrub_cnt_q <= scrub_cnt_q + ADDR_WIDTH'(1);
          // The last address is being issued now; RUN starts next cycle.
          if (scrub_cnt_q == LAST_ADDR) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end else begin
            state_q     <= SCRUB;
            init_done_q <= 1'b0;
          end
        end
        RUN: begin
          state_q     <= RUN;
          init_done_q <= 1'b1;
          scrub_cnt_q <= scrub_cnt_q;
        end
        default: begin
          state_q     <= RESET_STATE;
          init_done_q <= 1'b0;
          scrub_cnt_q <= '0;
        end
      endcase
    end
  end

  assign rsp_hit_a = tag_is_read_for(tag1_q, PORT_A);
  assign rsp_hit_b = tag_is_read_for(tag1_q, PORT_B);

  // Tag pipeline and per-port read-data capture; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag0_q        <= '0;
      tag1_q        <= '0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rsp_rdata_q <= '0;
      b_rsp_rdata_q <= '0;
    end else begin
      tag0_q        <= tag_d;
      tag1_q        <= tag0_q;
      a_rsp_valid_q <= rsp_hit_a;
      b_rsp_valid_q <= rsp_hit_b;
      if (rsp_hit_a) begin
        a_rsp_rdata_q <= mem_rd;
      end else begin
        a_rsp_rdata_q <= a_rsp_rdata_q;
      end
      if (rsp_hit_b) begin
        b_rsp_rdata_q <= mem_rd;
      end else begin
        b_rsp_rdata_q <= b_rsp_rdata_q;
      end
    end
  end

  assign init_done   = init_done_q;
  assign mem_ce      = mem_ce_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wd      = mem_wd_q;
  assign mem_w_mask  = mem_w_mask_q;
  assign a.rsp_valid = a_rsp_valid_q;
  assign a.rsp_rdata = a_rsp_rdata_q;
  assign b.rsp_valid = b_rsp_valid_q;
  assign b.rsp_rdata = b_rsp_rdata_q;

endmodule

// File: doc/sram_arbiter_2p.md
# sram_arbiter_2p

Two-requester controller for one single-port SRAM macro (`fakeram45_256x34`, 256×34, 1-cycle registered read).
- After reset it scrubs every word to zero, so no read ever returns X.
- It then round-robin arbitrates valid/ready requests from ports A and B onto the macro's single command port.
- It returns read data to the issuing port with fixed latency.
- It sits between the core's memory clients and the macro; the macro is instantiated beside it in the parent.

## Interface
Parameters:
- `BITS`, 34, data and mask width
- `ADDR_WIDTH`, 8, address width
- `WORD_DEPTH`, 256, words in the macro
- `SCRUB_EN`, 1, 1 = zero-fill the array after reset; 0 = go straight to RUN

Ports (`p` ∈ {`a`, `b`}):
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `init_done`  out  1  high once scrub is complete and requests are accepted.
- `p_req_valid`  in  1  request present.
- `p_req_ready`  out  1  request granted this cycle.
- `p_req_we`  in  1  1 = write, 0 = read.
- `p_req_addr`  in  ADDR_WIDTH  word address.
- `p_req_wdata`  in  BITS  write data.
- `p_req_wmask`  in  BITS  per-bit write enable.
- `p_rsp_valid`  out  1  one-cycle read-data strobe.
- `p_rsp_rdata`  out  BITS  read data; held until the next read response for this port.
- `mem_ce`, `mem_we`  out  1  macro chip enable and write enable (registered).
- `mem_addr`  out  ADDR_WIDTH  macro address (registered).
- `mem_wd`, `mem_w_mask`  out  BITS  macro write data and mask (registered).
- `mem_rd`  in  BITS  macro read data.

## Operation
FSM states: SCRUB, RUN.
- **Reset:** enters SCRUB when `SCRUB_EN`=1, otherwise RUN. Scrub counter = 0; priority pointer = A.

SCRUB:
- Each cycle drives `mem_ce`=1, `mem_we`=1, `mem_addr`=counter, `mem_wd`=0, `mem_w_mask`=all ones.
- Counter increments each cycle.
- After issuing address WORD_DEPTH−1, moves to RUN.
- Both `p_req_ready` are 0 throughout.
- `init_done` rises in the first RUN cycle and stays high until the next reset.

RUN arbitration:
- `p_req_ready` is combinational: 1 iff in RUN, `p_req_valid`=1, and p wins arbitration.
- At most one ready is high per cycle.
- Only one valid: that port wins.
- Both valid: the port indicated by the priority pointer wins.
- After any grant, the pointer moves to the non-granted port. With no grant it is unchanged.
- `ready` never depends on `p_rsp_*`. There is no response backpressure; requesters must sink responses.

Command register:
- A granted request is registered onto `mem_*` at the next edge: `mem_ce`=1, `mem_we`=`req_we`, and addr/wdata/wmask copied.
- With no grant: `mem_ce`=0, `mem_we`=0, `mem_addr`=0, `mem_wd`=0, `mem_w_mask`=0. This means no X ever reaches the macro address or WE inputs.

Responses:
- A 2-deep tag pipeline (valid, port, is_read) tracks every read.
- On a read, `mem_rd` is captured into `p_rsp_rdata` of the tagged port and `p_rsp_valid` pulses for one cycle.
- Writes produce no response.
- A write with `wmask`=0 is issued to the macro and leaves memory unchanged.

Hazards:
- A write to X accepted in cycle N followed by a read of X accepted in N+1 returns the new data. Commands reach the macro in order, one per cycle.

Reset mid-operation:
- Any cycle with `rst_n`=0 resets all state at that edge.
- In-flight responses are dropped and never asserted.
- Scrub restarts from address 0.

## Timing
- Reset values: `p_req_ready`=0, `p_rsp_valid`=0, `p_rsp_rdata`=0, `init_done`=0, all `mem_*`=0.
- Scrub duration: WORD_DEPTH cycles (256). `init_done`=1 in cycle 257 after reset release.
- Read latency: accept (valid & ready) in cycle N → `mem_*` in N+1 → `mem_rd` valid in N+2 → `p_rsp_valid`=1 with data in N+3.
- Throughput: one command per cycle total across both ports. Back-to-back reads from alternating ports give one response per cycle.
- Responses for each port return in request order.

## Structure
- Package `sram_arb_pkg`:
  - `BITS`, `ADDR_WIDTH`, `WORD_DEPTH` constants.
  - State enum {SCRUB, RUN}.
  - Request struct {we, addr, wdata, wmask}.
  - Response-tag struct {valid, port, is_read}.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with pointer register, inputs `req[1:0]`, output one-hot `gnt[1:0]`.
- The top holds the FSM, scrub counter, command register and tag pipeline.

## Test plan
- **Reset and scrub:** release reset with `SCRUB_EN`=1 → 256 consecutive writes of 0 to addresses 0..255. `init_done` rises in cycle 257. Reads of address 0x00 and 0xFF return 0, never X.
- **Single write then read:** A writes 0x3_0000_00AB to 0x10 with full mask, then A reads 0x10 → `a_rsp_valid` in accept+3 with 0x3_0000_00AB. `b_rsp_valid` stays 0.
- **Masked write:** write 0x3FFFFFFFF to 0x20, then write 0 with mask 0x0000000FF → read of 0x20 returns 0x3FFFFFF00.
- **Contention:** A and B both valid for 4 cycles → grants alternate A, B, A, B. With both reading distinct preloaded addresses, responses alternate in the same order at one per cycle.
- **Write-then-read hazard:** B writes 0x55 to 0x7 in cycle N; A reads 0x7 in N+1 → A receives 0x55.
- **Reset mid-read:** assert `rst_n`=0 one cycle after a read is accepted → no `rsp_valid` pulse, all outputs 0. Scrub restarts at address 0 after release.
